// File: rtl/aip_responder.sv
// AIP slave responder: host register/memory access, start handshake, DONE interrupt.
// Latency: host read data and core_y_data are valid one cycle after the sampling edge.
// Backpressure: none; every qualified strobe is consumed on the edge it is sampled.
module aip_responder #(
  parameter int                   DATAWIDTH = 32,
  parameter int                   MEM_Y_AW  = 6,
  parameter int                   MEM_Z_AW  = 6,
  parameter logic [DATAWIDTH-1:0] IP_ID_VAL = 32'h1000500B
) (
  input  logic                 clk,
  input  logic                 rst_a,
  input  logic                 en_s,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  input  logic                 write,
  input  logic                 read,
  input  logic                 start,
  input  logic [4:0]           conf_dbus,
  output logic                 int_req,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [MEM_Y_AW-1:0]  core_y_addr,
  output logic [DATAWIDTH-1:0] core_y_data,
  input  logic                 core_z_we,
  input  logic [MEM_Z_AW-1:0]  core_z_addr,
  input  logic [DATAWIDTH-1:0] core_z_data,
  output logic [DATAWIDTH-1:0] cfg_out
);

  localparam logic [4:0] C_Y_DAT  = 5'd0;
  localparam logic [4:0] C_Y_PTR  = 5'd1;
  localparam logic [4:0] C_Z_DAT  = 5'd2;
  localparam logic [4:0] C_Z_PTR  = 5'd3;
  localparam logic [4:0] C_CFG    = 5'd4;
  localparam logic [4:0] C_STATUS = 5'd30;
  localparam logic [4:0] C_IPID   = 5'd31;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  // Storage arrays carry no reset; only the control state around them does.
  logic [DATAWIDTH-1:0] mem_y [0:(1<<MEM_Y_AW)-1];
  logic [DATAWIDTH-1:0] mem_z [0:(1<<MEM_Z_AW)-1];

  state_e               state_q, state_d;
  logic                 core_start_q, core_start_d;
  logic                 start_q;
  logic [MEM_Y_AW-1:0]  ptr_y_q, ptr_y_d;
  logic [MEM_Z_AW-1:0]  ptr_z_q, ptr_z_d;
  logic [DATAWIDTH-1:0] cfg_q, cfg_d;
  logic [7:0]           mask_q, mask_d;
  logic                 flag_q, flag_d;
  logic                 int_req_q, int_req_d;
  logic [DATAWIDTH-1:0] data_out_q, data_out_d;
  logic [DATAWIDTH-1:0] core_y_q;

  logic                 wr_go, rd_go, start_go, busy, done_clr;
  logic [31:0]          status_w;

  // Write beats a simultaneous read; a start needs a fresh low-to-high request.
  assign wr_go    = en_s & write;
  assign rd_go    = en_s & read & ~write;
  assign start_go = en_s & start & ~start_q;
  assign busy     = (state_q == S_RUN);

  // Only flags[0] (DONE) is implemented; the other flag bits read as zero.
  assign status_w = {8'd0, mask_q, 7'd0, busy, 7'd0, flag_q};

  assign data_out    = data_out_q;
  assign int_req     = int_req_q;
  assign core_start  = core_start_q;
  assign core_y_data = core_y_q;
  assign cfg_out     = cfg_q;

  // FSM state register together with the start pulse and start-level history.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      state_q      <= S_IDLE;
      core_start_q <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_start_q <= core_start_d;
      start_q      <= start;
    end
  end

  // FSM next state: a start launches the core, its done pulse returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_go)  state_d = S_RUN;
      S_RUN:   if (core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: start requests while running are dropped.
  always_comb begin
    core_start_d = (state_q == S_IDLE) && start_go;
  end

  // Host decode: pointer/config/status updates and the read-data mux.
  always_comb begin
    ptr_y_d    = ptr_y_q;
    ptr_z_d    = ptr_z_q;
    cfg_d      = cfg_q;
    mask_d     = mask_q;
    data_out_d = data_out_q;
    done_clr   = 1'b0;
    if (wr_go) begin
      case (conf_dbus)
        C_Y_DAT:  ptr_y_d = ptr_y_q + 1'b1;
        C_Y_PTR:  ptr_y_d = data_in[MEM_Y_AW-1:0];
        C_Z_PTR:  ptr_z_d = data_in[MEM_Z_AW-1:0];
        C_CFG:    cfg_d   = data_in;
        C_STATUS: begin
          mask_d   = data_in[23:16];
          done_clr = data_in[0];
        end
        default: ;
      endcase
    end else if (rd_go) begin
      case (conf_dbus)
        C_Y_DAT: begin
          data_out_d = mem_y[ptr_y_q];
          ptr_y_d    = ptr_y_q + 1'b1;
        end
        C_Y_PTR: data_out_d = DATAWIDTH'(ptr_y_q);
        C_Z_DAT: begin
          data_out_d = mem_z[ptr_z_q];
          ptr_z_d    = ptr_z_q + 1'b1;
        end
        C_Z_PTR:  data_out_d = DATAWIDTH'(ptr_z_q);
        C_CFG:    data_out_d = cfg_q;
        C_STATUS: data_out_d = DATAWIDTH'(status_w);
        C_IPID:   data_out_d = IP_ID_VAL;
        default:  data_out_d = '0;
      endcase
    end
    // A done pulse wins over a same-edge write-1-to-clear.
    flag_d    = core_done | (flag_q & ~done_clr);
    int_req_d = ~(flag_d & mask_d[0]);
  end

  // Host-visible registers and the registered core read port.
  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      ptr_y_q    <= '0;
      ptr_z_q    <= '0;
      cfg_q      <= '0;
      mask_q     <= '0;
      flag_q     <= 1'b0;
      int_req_q  <= 1'b1;
      data_out_q <= '0;
      core_y_q   <= '0;
    end else begin
      ptr_y_q    <= ptr_y_d;
      ptr_z_q    <= ptr_z_d;
      cfg_q      <= cfg_d;
      mask_q     <= mask_d;
      flag_q     <= flag_d;
      int_req_q  <= int_req_d;
      data_out_q <= data_out_d;
      core_y_q   <= mem_y[core_y_addr];
    end
  end

  // Memory writes: host fills MEM_Y, core fills MEM_Z (host reads see old data).
  always_ff @(posedge clk) begin
    if (wr_go && (conf_dbus == C_Y_DAT)) mem_y[ptr_y_q] <= data_in;
    if (core_z_we) mem_z[core_z_addr] <= core_z_data;
  end

endmodule

// File: tb/tb_aip_responder.sv
// Randomized scoreboard bench for aip_responder against a behavioural model.
// Host reads push expected words; a negedge monitor pops and compares data_out.
// Control outputs (int_req, core_start, cfg_out, core_y_data) are checked directly.
module tb_aip_responder;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        en_s = 1'b0, write = 1'b0, read = 1'b0, start = 1'b0;
  logic        core_done = 1'b0, core_z_we = 1'b0;
  logic [31:0] data_in = '0, core_z_data = '0;
  logic [4:0]  conf_dbus = '0;
  logic [5:0]  core_y_addr = '0, core_z_addr = '0;
  logic [31:0] data_out, core_y_data, cfg_out;
  logic        int_req, core_start;

  aip_responder dut (
    .clk(clk), .rst_a(rst_a), .en_s(en_s), .data_in(data_in), .data_out(data_out),
    .write(write), .read(read), .start(start), .conf_dbus(conf_dbus),
    .int_req(int_req), .core_start(core_start), .core_done(core_done),
    .core_y_addr(core_y_addr), .core_y_data(core_y_data), .core_z_we(core_z_we),
    .core_z_addr(core_z_addr), .core_z_data(core_z_data), .cfg_out(cfg_out)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_dout = '0;
  logic        rd_fire = 1'b0;

  // Reference model: plain arrays and integers
  logic [31:0] my [64];
  logic [31:0] mz [64];
  int          py, pz;
  logic [31:0] m_cfg;
  logic [7:0]  m_mask;
  logic        m_flag, m_busy;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {8'd0, m_mask, 7'd0, m_busy, 7'd0, m_flag};
  endfunction

  function automatic logic m_irq();
    return !(m_flag && m_mask[0]);
  endfunction

  task automatic m_reset();
    py = 0; pz = 0; m_cfg = '0; m_mask = '0; m_flag = 1'b0; m_busy = 1'b0;
  endtask

  // Monitor: a qualified read edge means data_out carries the next scoreboard word
  always @(posedge clk) rd_fire <= en_s & read & ~write;

  always @(negedge clk) begin
    if (rd_fire) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL read data: got %h with no expected word queued", data_out);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("read data", data_out, e);
        last_dout = e;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_rd(input logic [4:0] c);
    logic [31:0] e;
    case (c)
      5'd0:  begin e = my[py]; py = (py + 1) % 64; end
      5'd1:  e = 32'(py);
      5'd2:  begin e = mz[pz]; pz = (pz + 1) % 64; end
      5'd3:  e = 32'(pz);
      5'd4:  e = m_cfg;
      5'd30: e = m_status();
      5'd31: e = 32'h1000500B;
      default: e = '0;
    endcase
    exp_q.push_back(e);
    en_s = 1'b1; read = 1'b1; conf_dbus = c;
    tick();
    read = 1'b0;
  endtask

  task automatic host_wr(input logic [4:0] c, input logic [31:0] d);
    case (c)
      5'd0:  begin my[py] = d; py = (py + 1) % 64; end
      5'd1:  py = int'(d[5:0]);
      5'd3:  pz = int'(d[5:0]);
      5'd4:  m_cfg = d;
      5'd30: begin m_mask = d[23:16]; if (d[0]) m_flag = 1'b0; end
      default: ;
    endcase
    en_s = 1'b1; write = 1'b1; conf_dbus = c; data_in = d;
    tick();
    write = 1'b0;
  endtask

  task automatic core_wr(input logic [5:0] a, input logic [31:0] d);
    mz[a] = d;
    core_z_we = 1'b1; core_z_addr = a; core_z_data = d;
    tick();
    core_z_we = 1'b0;
  endtask

  task automatic pulse_done();
    m_flag = 1'b1; m_busy = 1'b0;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  initial begin
    m_reset();
    #12;
    check("reset int_req", int_req, 1);
    check("reset core_start", core_start, 0);
    check("reset data_out", data_out, 0);
    check("reset core_y_data", core_y_data, 0);
    check("reset cfg_out", cfg_out, 0);
    @(negedge clk); rst_a = 1'b0;
    tick();

    // Identity and status after reset
    host_rd(5'd31);
    host_rd(5'd30);
    check("irq idle", int_req, m_irq());

    // Burst read-back of MEM_Y
    host_wr(5'd1, 32'd0);
    for (int i = 1; i <= 5; i++) host_wr(5'd0, 32'(i));
    host_wr(5'd1, 32'd0);
    for (int i = 0; i < 5; i++) host_rd(5'd0);
    host_rd(5'd1);

    // MEM_Z pointer wrap and host-side write ignored
    host_wr(5'd3, 32'd62);
    core_wr(6'd62, 32'hAAAA_0001);
    core_wr(6'd63, 32'hBBBB_0002);
    core_wr(6'd0,  32'hCCCC_0003);
    for (int i = 0; i < 3; i++) host_rd(5'd2);
    host_wr(5'd2, 32'hDEAD_BEEF);
    host_wr(5'd3, 32'd62);
    host_rd(5'd2);

    // Start handshake and DONE interrupt
    host_wr(5'd30, 32'h0001_0000);
    en_s = 1'b1; start = 1'b1;
    tick(); check("core_start pulse", core_start, 1); m_busy = 1'b1;
    tick(); check("core_start held low", core_start, 0);
    start = 1'b0;
    tick(); check("core_start idle", core_start, 0);
    host_rd(5'd30);
    start = 1'b1;
    tick(); check("start while busy", core_start, 0);
    start = 1'b0;
    tick(); check("start while busy 2", core_start, 0);
    pulse_done();
    check("irq after done", int_req, m_irq());
    host_rd(5'd30);
    host_wr(5'd30, 32'h0001_0001);
    check("irq after clear", int_req, m_irq());

    // Done and clear on the same edge: set wins
    en_s = 1'b1; write = 1'b1; conf_dbus = 5'd30; data_in = 32'h0001_0001; core_done = 1'b1;
    m_mask = 8'h01; m_flag = 1'b1;
    tick();
    write = 1'b0; core_done = 1'b0;
    host_rd(5'd30);
    check("irq collision", int_req, m_irq());

    // Masked done leaves interrupt idle
    host_wr(5'd30, 32'h0000_0001);
    pulse_done();
    check("irq masked", int_req, m_irq());
    host_rd(5'd30);
    host_wr(5'd30, 32'h0000_0001);

    // en_s low: writes, reads and starts ignored
    host_wr(5'd4, 32'hA5A5_0F0F);
    en_s = 1'b0; write = 1'b1; conf_dbus = 5'd4; data_in = 32'h5;
    tick(); write = 1'b0;
    check("cfg with en_s low", cfg_out, m_cfg);
    read = 1'b1; conf_dbus = 5'd31;
    tick(); read = 1'b0;
    tick(); check("read with en_s low", data_out, last_dout);
    start = 1'b1;
    tick(); check("start with en_s low", core_start, 0);
    start = 1'b0; en_s = 1'b1;
    tick();

    // Write and read together: write wins, data_out holds
    write = 1'b1; read = 1'b1; conf_dbus = 5'd4; data_in = 32'h0000_1234; m_cfg = 32'h0000_1234;
    tick(); write = 1'b0; read = 1'b0;
    tick();
    check("read dropped", data_out, last_dout);
    check("cfg write wins", cfg_out, m_cfg);
    host_rd(5'd5);
    host_rd(5'd7);

    // Host read and core write to the same MEM_Z word: host sees old data
    exp_q.push_back(mz[pz]);
    mz[pz] = 32'h1357_9BDF;
    en_s = 1'b1; read = 1'b1; conf_dbus = 5'd2;
    core_z_we = 1'b1; core_z_addr = 6'(pz); core_z_data = 32'h1357_9BDF;
    pz = (pz + 1) % 64;
    tick(); read = 1'b0; core_z_we = 1'b0;

    // Fill both memories with random data
    host_wr(5'd1, 32'd0);
    for (int i = 0; i < 64; i++) host_wr(5'd0, $urandom);
    for (int i = 0; i < 64; i++) core_wr(6'(i), $urandom);
    for (int i = 0; i < 6; i++) begin
      logic [5:0] a;
      a = 6'($urandom_range(0, 63));
      core_y_addr = a;
      tick();
      check("core_y_data", core_y_data, my[a]);
    end

    // Randomized host/core traffic
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: host_wr(5'd0, $urandom);
        1: host_wr(5'd1, $urandom);
        2: host_rd(5'd0);
        3: host_rd(5'd1);
        4: core_wr(6'($urandom_range(0, 63)), $urandom);
        5: host_wr(5'd3, $urandom);
        6: host_rd(5'd2);
        7: host_rd(5'($urandom_range(0, 31)));
        8: host_wr(5'd4, $urandom);
        default: host_rd(5'd3);
      endcase
    end
    check("irq after traffic", int_req, m_irq());

    // Reset while running
    start = 1'b1;
    tick(); start = 1'b0;
    check("core_start before reset", core_start, 1);
    #2 rst_a = 1'b1;
    #1;
    check("reset aborts core_start", core_start, 0);
    check("reset int_req", int_req, 1);
    check("reset cfg_out", cfg_out, 0);
    m_reset();
    @(negedge clk); rst_a = 1'b0;
    tick();
    host_rd(5'd30);
    host_rd(5'd4);
    host_rd(5'd1);
    host_rd(5'd0);

    repeat (3) tick();
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
